// File: rtl/major_state_seq_if.sv
// rtl/major_state_seq_if.sv - sequencer <-> datapath/front-panel signal bundle
// Ports (master = sequencer side):
//   instruction [0:11] IR from ma, bit 0 is the MSB (op = [0:2])
//   cont, stop, sstep  front-panel levels
//   state [SW-1:0]     current minor state
//   run, halt_ack      run status and halt-entry pulse
//   int_req, int_ena, int_ack  only with MAJOR_SEQ_INTERRUPT_EN
interface major_state_seq_if #(
    parameter int SW = 5
);
    logic [0:11]   instruction;
    logic          cont;
    logic          stop;
    logic          sstep;
    logic [SW-1:0] state;
    logic          run;
    logic          halt_ack;
`ifdef MAJOR_SEQ_INTERRUPT_EN
    logic          int_req;
    logic          int_ena;
    logic          int_ack;

    modport master (
        input  instruction, cont, stop, sstep, int_req, int_ena,
        output state, run, halt_ack, int_ack
    );
    modport slave (
        output instruction, cont, stop, sstep, int_req, int_ena,
        input  state, run, halt_ack, int_ack
    );
`else
    modport master (
        input  instruction, cont, stop, sstep,
        output state, run, halt_ack
    );
    modport slave (
        output instruction, cont, stop, sstep,
        input  state, run, halt_ack
    );
`endif
endinterface

// File: rtl/major_state_seq.sv
// rtl/major_state_seq.sv - PDP-8e major/minor state sequencer with run/halt control
// Optional feature macro: MAJOR_SEQ_INTERRUPT_EN (adds int_req/int_ena/int_ack).
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset (state returns to H0 immediately)
//   bus    major_state_seq_if.master: instruction/cont/stop/sstep in,
//          state/run/halt_ack out
module major_state_seq #(
    parameter int SW = 5
) (
    input  logic               clk,
    input  logic               reset,
    major_state_seq_if.master  bus
);

    typedef enum logic [SW-1:0] {
        F0 = SW'(0),  F1 = SW'(1),  F2 = SW'(2),  F3 = SW'(3),
        D0 = SW'(4),  D1 = SW'(5),  D2 = SW'(6),  D3 = SW'(7),
        E0 = SW'(8),  E1 = SW'(9),  E2 = SW'(10), E3 = SW'(11),
        H0 = SW'(12), H1 = SW'(13), H2 = SW'(14), H3 = SW'(15)
    } state_t;

    state_t     state_q, state_d;
    logic       run_q, run_d;
    logic       halt_ack_q, halt_ack_d;
    logic       halt_pend_q, halt_pend_d;
    logic       cont_seen_q, cont_seen_d;
    logic       cont_prev_q;

    logic [2:0] op;
    logic       ind;
    logic       mem_ref;
    logic       is_hlt;
    logic       in_h;
    logic       eoi;
    logic       halt_now;
    logic       cont_rise;
    logic       unused_ir_bits;

`ifdef MAJOR_SEQ_INTERRUPT_EN
    logic       int_ack_q, int_take;
`endif

    // Address/page bits of the IR are decoded by ma, not here.
    assign unused_ir_bits = ^bus.instruction[4:9];

    assign bus.state    = state_q;
    assign bus.run      = run_q;
    assign bus.halt_ack = halt_ack_q;
`ifdef MAJOR_SEQ_INTERRUPT_EN
    assign bus.int_ack  = int_ack_q;
`endif

    always_comb begin
        op        = bus.instruction[0:2];
        ind       = bus.instruction[3];
        mem_ref   = (op < 3'd6);
        is_hlt    = (op == 3'd7) && ind && !bus.instruction[11] && bus.instruction[10];
        in_h      = (state_q == H0) || (state_q == H1) || (state_q == H2) || (state_q == H3);
        cont_rise = bus.cont && !cont_prev_q;

        // stop in the boundary cycle itself must halt too, so the pending
        // flag is combined with the live request rather than waited for.
        halt_now  = halt_pend_q || (bus.stop && run_q) || bus.sstep ||
                    ((state_q == F3) && is_hlt);

        eoi     = 1'b0;
        state_d = H0;
        case (state_q)
            F0: state_d = F1;
            F1: state_d = F2;
            F2: state_d = F3;
            F3: begin
                if (mem_ref && ind)
                    state_d = D0;
                else if (mem_ref && (op != 3'd5))
                    state_d = E0;
                else
                    eoi = 1'b1;
            end
            D0: state_d = D1;
            D1: state_d = D2;
            D2: state_d = D3;
            D3: begin
                if (op == 3'd5)
                    eoi = 1'b1;
                else
                    state_d = E0;
            end
            E0: state_d = E1;
            E1: state_d = E2;
            E2: state_d = E3;
            E3: eoi = 1'b1;
            H0: state_d = H1;
            H1: state_d = H2;
            H2: state_d = H3;
            H3: state_d = (cont_seen_q && !bus.stop) ? F0 : H0;
            default: state_d = H0;
        endcase

        if (eoi)
            state_d = halt_now ? H0 : F0;

`ifdef MAJOR_SEQ_INTERRUPT_EN
        // Halt wins; otherwise the interrupt fetch reuses F0 (ma forces JMS 0).
        int_take = eoi && !halt_now && bus.int_req && bus.int_ena;
`endif

        run_d      = !((state_d == H0) || (state_d == H1) || (state_d == H2) || (state_d == H3));
        halt_ack_d = (state_d == H0) && !in_h;

        halt_pend_d = halt_pend_q || (bus.stop && run_q);
        if ((state_d == H0) && !in_h)
            halt_pend_d = 1'b0;

        // Only edges seen while halted count, so a held CONT cannot re-launch.
        cont_seen_d = cont_seen_q;
        if (in_h) begin
            if ((state_q == H3) && (state_d == F0))
                cont_seen_d = 1'b0;
            else if (cont_rise)
                cont_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= H0;
            run_q       <= 1'b0;
            halt_ack_q  <= 1'b0;
            halt_pend_q <= 1'b0;
            cont_seen_q <= 1'b0;
            cont_prev_q <= 1'b0;
`ifdef MAJOR_SEQ_INTERRUPT_EN
            int_ack_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            halt_ack_q  <= halt_ack_d;
            halt_pend_q <= halt_pend_d;
            cont_seen_q <= cont_seen_d;
            cont_prev_q <= bus.cont;
`ifdef MAJOR_SEQ_INTERRUPT_EN
            int_ack_q   <= int_take;
`endif
        end
    end

endmodule

// File: tb/tb_major_state_seq.sv
// tb/tb_major_state_seq.sv - scoreboard bench for major_state_seq
module tb_major_state_seq;

    localparam logic [4:0] F0 = 5'd0,  F1 = 5'd1,  F2 = 5'd2,  F3 = 5'd3;
    localparam logic [4:0] D0 = 5'd4,  D1 = 5'd5,  D2 = 5'd6,  D3 = 5'd7;
    localparam logic [4:0] E0 = 5'd8,  E1 = 5'd9,  E2 = 5'd10, E3 = 5'd11;
    localparam logic [4:0] H0 = 5'd12, H1 = 5'd13, H2 = 5'd14, H3 = 5'd15;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc_no = 0;

    logic [6:0] sb_q[$];

    major_state_seq_if bus ();

    major_state_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One visible cycle: expected outputs after this posedge.
    task automatic cyc(input logic [4:0] st, input logic r, input logic a);
        @(posedge clk);
        #1;
        sb_q.push_back({st, r, a});
    endtask

    task automatic seq4(input logic [4:0] base);
        for (int i = 0; i < 4; i++) cyc(base + 5'(i), 1'b1, 1'b0);
    endtask

    task automatic direct_check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d run=%0b ack=%0b, expected state=%0d run=%0b ack=%0b",
                     name, act[6:2], act[1], act[0], exp[6:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: the DUT presents state/run/halt_ack every cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            logic [6:0] exp;
            logic [6:0] act;
            exp = sb_q.pop_front();
            act = {bus.state, bus.run, bus.halt_ack};
            cyc_no++;
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle %0d: got state=%0d run=%0b ack=%0b, expected state=%0d run=%0b ack=%0b",
                         cyc_no, act[6:2], act[1], act[0], exp[6:2], exp[1], exp[0]);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.instruction = 12'o0000;
        bus.cont        = 1'b0;
        bus.stop        = 1'b0;
        bus.sstep       = 1'b0;
`ifdef MAJOR_SEQ_INTERRUPT_EN
        bus.int_req     = 1'b0;
        bus.int_ena     = 1'b0;
`endif
        #1;
        direct_check("reset_state", {bus.state, bus.run, bus.halt_ack}, {H0, 1'b0, 1'b0});
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Halt loop with cont low
        cyc(H1, 0, 0); cyc(H2, 0, 0); cyc(H3, 0, 0); cyc(H0, 0, 0);
        // CONT pulse in H1, JMP direct
        cyc(H1, 0, 0); bus.cont = 1'b1; bus.instruction = 12'o5210;
        cyc(H2, 0, 0); bus.cont = 1'b0;
        cyc(H3, 0, 0);
        seq4(F0);
        cyc(F0, 1, 0); bus.instruction = 12'o5410;           // JMP I
        cyc(F1, 1, 0); cyc(F2, 1, 0); cyc(F3, 1, 0);
        seq4(D0);
        cyc(F0, 1, 0); bus.instruction = 12'o2231;           // ISZ
        cyc(F1, 1, 0); cyc(F2, 1, 0); cyc(F3, 1, 0);
        seq4(E0);
        cyc(F0, 1, 0); bus.instruction = 12'o4277;           // JMS
        cyc(F1, 1, 0); cyc(F2, 1, 0); cyc(F3, 1, 0);
        seq4(E0);
        cyc(F0, 1, 0); bus.instruction = 12'o1610;           // TAD I
        cyc(F1, 1, 0); cyc(F2, 1, 0); cyc(F3, 1, 0);
        seq4(D0);
        seq4(E0);
        cyc(F0, 1, 0); bus.instruction = 12'o7402;           // HLT
        cyc(F1, 1, 0); cyc(F2, 1, 0); cyc(F3, 1, 0);
        cyc(H0, 0, 1); cyc(H1, 0, 0);

        // Restart, DCA with STOP during E1
        bus.cont = 1'b1; bus.instruction = 12'o3277;
        cyc(H2, 0, 0); bus.cont = 1'b0;
        cyc(H3, 0, 0);
        seq4(F0);
        cyc(E0, 1, 0);
        cyc(E1, 1, 0); bus.stop = 1'b1;
        cyc(E2, 1, 0); bus.stop = 1'b0;
        cyc(E3, 1, 0);
        cyc(H0, 0, 1);

        // Single step: one CONT edge held high -> exactly one instruction
        cyc(H1, 0, 0); bus.sstep = 1'b1; bus.cont = 1'b1; bus.instruction = 12'o5210;
        cyc(H2, 0, 0); cyc(H3, 0, 0);
        seq4(F0);
        cyc(H0, 0, 1);
        cyc(H1, 0, 0); cyc(H2, 0, 0); cyc(H3, 0, 0); cyc(H0, 0, 0);
        cyc(H1, 0, 0); cyc(H2, 0, 0); cyc(H3, 0, 0); cyc(H0, 0, 0);
        bus.cont = 1'b0; bus.sstep = 1'b0;

        // STOP and CONT together at H3 stays halted; restart once STOP drops
        cyc(H1, 0, 0); bus.cont = 1'b1; bus.stop = 1'b1; bus.instruction = 12'o2231;
        cyc(H2, 0, 0); bus.cont = 1'b0;
        cyc(H3, 0, 0);
        cyc(H0, 0, 0);
        cyc(H1, 0, 0); bus.stop = 1'b0;
        cyc(H2, 0, 0); cyc(H3, 0, 0);
        seq4(F0);
        cyc(E0, 1, 0); cyc(E1, 1, 0); cyc(E2, 1, 0);
        cyc(E3, 1, 0); bus.stop = 1'b1;                       // STOP in E3
        cyc(H0, 0, 1); bus.stop = 1'b0;

        // Reset asserted mid-E1
        cyc(H1, 0, 0); bus.cont = 1'b1;
        cyc(H2, 0, 0); bus.cont = 1'b0;
        cyc(H3, 0, 0);
        seq4(F0);
        cyc(E0, 1, 0);
        @(posedge clk);
        #1;
        direct_check("pre_reset_e1", {bus.state, bus.run, bus.halt_ack}, {E1, 1'b1, 1'b0});
        #2 reset = 1'b1;
        #1;
        direct_check("async_reset", {bus.state, bus.run, bus.halt_ack}, {H0, 1'b0, 1'b0});
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(H1, 0, 0); cyc(H2, 0, 0); cyc(H3, 0, 0); cyc(H0, 0, 0);
        cyc(H1, 0, 0); cyc(H2, 0, 0); cyc(H3, 0, 0); cyc(H0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
